// File: rtl/control_id_pipe_if.sv
// ID -> ID/EX control pipe bundle: instruction fields and pipeline controls in,
// registered control word, stall, illegal pulse and bubble count out.
interface control_id_pipe_if #(
    parameter int OPW  = 6,
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic            id_valid_i;
    logic [OPW-1:0]  id_op_i;
    logic [REGW-1:0] id_rs_i;
    logic [REGW-1:0] id_rt_i;
    logic [REGW-1:0] id_rd_i;
    logic            flush_i;
    logic            ex_hold_i;

    logic            ex_valid_o;
    logic [1:0]      ex_alu_op_o;
    logic            ex_reg_dst_o;
    logic            ex_jump_o;
    logic            ex_branch_o;
    logic            ex_mem_read_o;
    logic            ex_mem_write_o;
    logic            ex_mem_to_reg_o;
    logic            ex_alu_src_o;
    logic            ex_reg_write_o;
    logic [REGW-1:0] ex_wr_reg_o;
    logic            stall_o;
    logic            illegal_o;
    logic [CNTW-1:0] bubble_cnt_o;

    // ID side / pipeline control
    modport master (
        output id_valid_i, id_op_i, id_rs_i, id_rt_i, id_rd_i, flush_i, ex_hold_i,
        input  ex_valid_o, ex_alu_op_o, ex_reg_dst_o, ex_jump_o, ex_branch_o,
               ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_alu_src_o,
               ex_reg_write_o, ex_wr_reg_o, stall_o, illegal_o, bubble_cnt_o
    );

    // decoder pipe
    modport slave (
        input  id_valid_i, id_op_i, id_rs_i, id_rt_i, id_rd_i, flush_i, ex_hold_i,
        output ex_valid_o, ex_alu_op_o, ex_reg_dst_o, ex_jump_o, ex_branch_o,
               ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_alu_src_o,
               ex_reg_write_o, ex_wr_reg_o, stall_o, illegal_o, bubble_cnt_o
    );
endinterface

// File: rtl/control_id_pipe.sv
// Pipelined ID-stage control decoder: decodes the opcode into an ID/EX control
// register, detects load-use hazards (one bubble, PC/IF-ID stalled), honours
// flush and downstream hold, and keeps a saturating count of hazard bubbles.
module control_id_pipe #(
    parameter int OPW      = 6,
    parameter int REGW     = 5,
    parameter int CNTW     = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    control_id_pipe_if.slave  bus
);
    // ID/EX register contents; an all-zero word is a bubble
    typedef struct packed {
        logic            valid;
        logic [1:0]      alu_op;
        logic            reg_dst;
        logic            jump;
        logic            branch;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            reg_write;
        logic [REGW-1:0] wr_reg;
    } idex_t;

    idex_t           ex_q;
    idex_t           dec;
    logic            illegal_q;
    logic [CNTW-1:0] cnt_q;
    logic [5:0]      c;
    logic            op_hi_nz;
    logic            wr_hit;
    logic            zero_ok;
    logic            hazard;
    logic            unused_op4;

    assign c          = bus.id_op_i[5:0];
    assign unused_op4 = c[4];   // bit 4 takes no part in the decode

    // opcode bits above the 6-bit field must be zero; none exist at OPW==6
    generate
        if (OPW > 6) begin : g_hi
            assign op_hi_nz = |bus.id_op_i[OPW-1:6];
        end else begin : g_nohi
            assign op_hi_nz = 1'b0;
        end
    endgenerate

    // combinational control decode of the instruction sitting in ID
    always_comb begin
        dec            = '0;
        dec.valid      = 1'b1;
        dec.jump       = c[1] & ~c[0];
        dec.branch     = c[2];
        dec.mem_read   = c[0] & c[1] & ~c[3];
        dec.mem_to_reg = c[0] & c[1] & ~c[3];
        dec.mem_write  = c[0] & c[1] & c[3];
        dec.alu_op     = {~c[5] & ~c[2], c[2]};
        dec.alu_src    = c[0] & c[1];
        dec.reg_write  = ~((c[5] ^ c[1]) | c[3] | c[2]);
        dec.reg_dst    = ~c[1];
        dec.wr_reg     = c[1] ? bus.id_rt_i : bus.id_rd_i;
    end

    // load in EX whose destination feeds an ID source -> one bubble
    assign wr_hit  = (ex_q.wr_reg == bus.id_rs_i) | (ex_q.wr_reg == bus.id_rt_i);
    assign zero_ok = ZERO_REG ? (ex_q.wr_reg != '0) : 1'b1;
    assign hazard  = bus.id_valid_i & ex_q.valid & ex_q.mem_read & wr_hit & zero_ok;

    // stall freezes PC and IF/ID; a flush overrides both hold and hazard
    assign bus.stall_o = ~bus.flush_i & (bus.ex_hold_i | hazard);

    // ID/EX update in priority order: flush, hold, hazard, decode, illegal, idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            illegal_q <= 1'b0;
            if (bus.flush_i) begin
                ex_q <= '0;
            end else if (bus.ex_hold_i) begin
                ex_q <= ex_q;
            end else if (hazard) begin
                ex_q <= '0;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end else if (bus.id_valid_i && !op_hi_nz) begin
                ex_q <= dec;
            end else begin
                ex_q      <= '0;
                illegal_q <= bus.id_valid_i;
            end
        end
    end

    assign bus.ex_valid_o      = ex_q.valid;
    assign bus.ex_alu_op_o     = ex_q.alu_op;
    assign bus.ex_reg_dst_o    = ex_q.reg_dst;
    assign bus.ex_jump_o       = ex_q.jump;
    assign bus.ex_branch_o     = ex_q.branch;
    assign bus.ex_mem_read_o   = ex_q.mem_read;
    assign bus.ex_mem_write_o  = ex_q.mem_write;
    assign bus.ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign bus.ex_alu_src_o    = ex_q.alu_src;
    assign bus.ex_reg_write_o  = ex_q.reg_write;
    assign bus.ex_wr_reg_o     = ex_q.wr_reg;
    assign bus.illegal_o       = illegal_q;
    assign bus.bubble_cnt_o    = cnt_q;
endmodule
